// File: rtl/booth_operand_issuer.sv
// booth_operand_issuer: operand FIFO and issue sequencer in front of booth_multiplier.
// Operand pairs are queued, issued one at a time with a single-cycle start pulse,
// and each product is held on a valid/ready result stream until it is taken.
// Optional watchdog: define BOOTH_ISSUER_TIMEOUT_EN to abort multiplies that never finish.
module booth_operand_issuer #(
  parameter int WIDTH_INPUT    = 16,
  parameter int WIDTH_OUTPUT   = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [WIDTH_INPUT-1:0]        op_a,
  input  logic [WIDTH_INPUT-1:0]        op_b,
  output logic [WIDTH_INPUT-1:0]        mul_in_a,
  output logic [WIDTH_INPUT-1:0]        mul_in_b,
  output logic                          mul_valid_in,
  input  logic                          mul_valid_out,
  input  logic [WIDTH_OUTPUT-1:0]       mul_product,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [WIDTH_OUTPUT-1:0]       res_product,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Catch illegal parameter combinations at elaboration
  if (WIDTH_OUTPUT != 2 * WIDTH_INPUT) begin : g_bad_width
    $error("booth_operand_issuer: WIDTH_OUTPUT must be 2*WIDTH_INPUT");
  end
  if ((FIFO_DEPTH < 2) || ((1 << PTR_W) != FIFO_DEPTH)) begin : g_bad_depth
    $error("booth_operand_issuer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("booth_operand_issuer: TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]              state_q, state_d;
  logic [WIDTH_INPUT-1:0]  fifo_a_q [FIFO_DEPTH];
  logic [WIDTH_INPUT-1:0]  fifo_b_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WIDTH_INPUT-1:0]  mul_in_a_q, mul_in_a_d;
  logic [WIDTH_INPUT-1:0]  mul_in_b_q, mul_in_b_d;
  logic                    res_valid_q, res_valid_d;
  logic [WIDTH_OUTPUT-1:0] res_product_q, res_product_d;
  logic                    push;
  logic                    pop;
  logic                    capture;
  logic                    slot_free;
  logic                    wd_expire;

  assign op_ready  = reset && (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = op_valid && op_ready;
  assign slot_free = !res_valid_q || res_ready;

  // Issue sequencer: pop into the operand registers, pulse start, wait for done
  always_comb begin
    state_d       = state_q;
    mul_in_a_d    = mul_in_a_q;
    mul_in_b_d    = mul_in_b_q;
    res_product_d = res_product_q;
    pop           = 1'b0;
    capture       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && slot_free) begin
          pop        = 1'b1;
          mul_in_a_d = fifo_a_q[rd_ptr_q];
          mul_in_b_d = fifo_b_q[rd_ptr_q];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_valid_out) begin
          capture       = 1'b1;
          res_product_d = mul_product;
          state_d       = ST_IDLE;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    res_valid_d = res_valid_q;
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (capture) begin
      res_valid_d = 1'b1;
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= op_a;
      fifo_b_q[wr_ptr_q] <= op_b;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mul_in_a_q    <= '0;
      mul_in_b_q    <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mul_in_a_q    <= mul_in_a_d;
      mul_in_b_q    <= mul_in_b_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
    end
  end

`ifdef BOOTH_ISSUER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // Fires on the edge where the WAIT count would reach TIMEOUT_CYCLES
  assign wd_expire = (state_q == ST_WAIT) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog count restarts on WAIT entry; a product on the expiry edge wins
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (wd_expire && !mul_valid_out) begin
      timeout_err_d = 1'b1;
    end
  end

  // Watchdog registers; the error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign mul_in_a     = mul_in_a_q;
  assign mul_in_b     = mul_in_b_q;
  assign mul_valid_in = (state_q == ST_ISSUE);
  assign res_valid    = res_valid_q;
  assign res_product  = res_product_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_operand_issuer.sv
// Directed self-checking bench for booth_operand_issuer with a stub multiplier
// of programmable latency. Timeout scenario depends on BOOTH_ISSUER_TIMEOUT_EN.
module tb_booth_operand_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] mul_in_a;
  logic [15:0] mul_in_b;
  logic        mul_valid_in;
  logic        mul_valid_out;
  logic [31:0] mul_product;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_product;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        timeout_err;

  int assertCount = 0;
  int failCount   = 0;

  // Stub multiplier controls
  int          stubLatency = 17;
  bit          stubNever   = 1'b0;
  logic        forceDone   = 1'b0;
  logic        stubBusy;
  logic        stubDone;
  int          stubCnt;
  logic [31:0] stubProd;

  booth_operand_issuer #(
    .WIDTH_INPUT(16),
    .WIDTH_OUTPUT(32),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a(op_a),
    .op_b(op_b),
    .mul_in_a(mul_in_a),
    .mul_in_b(mul_in_b),
    .mul_valid_in(mul_valid_in),
    .mul_valid_out(mul_valid_out),
    .mul_product(mul_product),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_product(res_product),
    .fifo_count(fifo_count),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Stub multiplier: done is sampled high stubLatency edges after valid_in is sampled
  always @(posedge clk) begin
    if (!reset) begin
      stubBusy <= 1'b0;
      stubDone <= 1'b0;
      stubCnt  <= 0;
      stubProd <= '0;
    end else begin
      stubDone <= 1'b0;
      if (mul_valid_in) begin
        if (!stubNever) begin
          stubBusy <= 1'b1;
          stubCnt  <= 1;
          stubProd <= 32'(mul_in_a) * 32'(mul_in_b);
        end
      end else if (stubBusy) begin
        if (stubCnt == stubLatency - 1) begin
          stubDone <= 1'b1;
          stubBusy <= 1'b0;
        end else begin
          stubCnt <= stubCnt + 1;
        end
      end
    end
  end

  // Forced done pulses model a spurious or stale multiplier completion
  assign mul_valid_out = stubDone | forceDone;
  assign mul_product   = forceDone ? 32'hDEAD_BEEF : stubProd;

  // Single comparison point: count it and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the operand stream
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b);
    op_valid = v;
    op_a     = a;
    op_b     = b;
  endtask

  // Wait a bounded number of cycles for a result; expiry counts as a failure
  task automatic waitResult(input int maxCycles, input string tag);
    int n;
    n = 0;
    while (!res_valid && n < maxCycles) begin
      tick();
      n++;
    end
    if (!res_valid) checkOutput(tag, 32'(res_valid), 32'd1);
  endtask

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int   pushed;
    int   issues;
    int   got;
    int   pulses;
    bit   stable;
    bit   early;
    logic willPush;
    logic [31:0] expProd [6];

    expProd[0] = 32'd1;  expProd[1] = 32'd4;  expProd[2] = 32'd9;
    expProd[3] = 32'd16; expProd[4] = 32'd25; expProd[5] = 32'd36;

    // Reset state: every output must read zero while reset is held low
    reset     = 1'b0;
    res_ready = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0);
    repeat (3) tick();
    checkOutput("rst_op_ready", 32'(op_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_product", res_product, 32'd0);
    checkOutput("rst_mul_in_a", 32'(mul_in_a), 32'd0);
    checkOutput("rst_mul_in_b", 32'(mul_in_b), 32'd0);
    checkOutput("rst_mul_valid_in", 32'(mul_valid_in), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("op_ready_after_rst", 32'(op_ready), 32'd1);

    // Single op 3x5 with latency 17: result visible 19 edges after the push edge
    $display("[TB] single op");
    stubLatency = 17;
    applyStimulus(1'b1, 16'd3, 16'd5);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    checkOutput("single_count_after_push", 32'(fifo_count), 32'd1);
    checkOutput("single_no_issue_yet", 32'(mul_valid_in), 32'd0);
    pulses = 0;
    stable = 1'b1;
    early  = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (mul_valid_in) pulses++;
      if (k == 1) checkOutput("single_issue_at_e1", 32'(mul_valid_in), 32'd1);
      if (mul_in_a !== 16'd3 || mul_in_b !== 16'd5) stable = 1'b0;
      if (k < 19 && res_valid) early = 1'b1;
    end
    checkOutput("single_valid_in_pulses", 32'(pulses), 32'd1);
    checkOutput("single_operands_stable", 32'(stable), 32'd1);
    checkOutput("single_no_early_result", 32'(early), 32'd0);
    checkOutput("single_res_valid_e19", 32'(res_valid), 32'd1);
    checkOutput("single_res_product", res_product, 32'd15);
    checkOutput("single_idle_after", 32'(busy), 32'd0);
    tick();
    checkOutput("single_res_taken", 32'(res_valid), 32'd0);

    // Backpressure: result held, FIFO fills to 4, sixth pair stalls
    $display("[TB] backpressure");
    res_ready   = 1'b0;
    stubLatency = 3;
    pushed      = 0;
    issues      = 0;
    for (int c = 0; c < 12; c++) begin
      willPush = (pushed < 6) && op_ready;
      applyStimulus(pushed < 6, 16'(pushed + 1), 16'(pushed + 1));
      tick();
      if (willPush) pushed++;
      if (mul_valid_in) issues++;
    end
    checkOutput("bp_pushed_before_release", 32'(pushed), 32'd5);
    checkOutput("bp_fifo_full", 32'(fifo_count), 32'd4);
    checkOutput("bp_op_ready_low", 32'(op_ready), 32'd0);
    checkOutput("bp_issues", 32'(issues), 32'd1);
    checkOutput("bp_result_held", 32'(res_valid), 32'd1);
    checkOutput("bp_held_product", res_product, 32'd1);
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 150 && got < 6; c++) begin
      if (res_valid) begin
        checkOutput($sformatf("bp_prod_%0d", got), res_product, expProd[got]);
        got++;
      end
      willPush = (pushed < 6) && op_ready;
      applyStimulus(pushed < 6, 16'(pushed + 1), 16'(pushed + 1));
      tick();
      if (willPush) pushed++;
    end
    applyStimulus(1'b0, 16'd0, 16'd0);
    checkOutput("bp_results_got", 32'(got), 32'd6);
    checkOutput("bp_pushed_total", 32'(pushed), 32'd6);
    checkOutput("bp_fifo_drained", 32'(fifo_count), 32'd0);

    // Spurious done in IDLE and in ISSUE must be ignored
    $display("[TB] spurious done");
    tick();
    forceDone = 1'b1;
    tick();
    forceDone = 1'b0;
    checkOutput("spur_idle_no_result", 32'(res_valid), 32'd0);
    checkOutput("spur_idle_busy", 32'(busy), 32'd0);
    stubLatency = 4;
    applyStimulus(1'b1, 16'd2, 16'd8);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    tick();
    checkOutput("spur_in_issue", 32'(mul_valid_in), 32'd1);
    forceDone = 1'b1;
    tick();
    forceDone = 1'b0;
    checkOutput("spur_issue_no_result", 32'(res_valid), 32'd0);
    checkOutput("spur_issue_to_wait", 32'(busy), 32'd1);
    checkOutput("spur_issue_pulse_over", 32'(mul_valid_in), 32'd0);
    waitResult(20, "spur_result_wait");
    checkOutput("spur_real_product", res_product, 32'd16);
    tick();

`ifdef BOOTH_ISSUER_TIMEOUT_EN
    // Watchdog: first op never completes, second (7x9) must still finish
    $display("[TB] timeout");
    stubNever = 1'b1;
    applyStimulus(1'b1, 16'd5, 16'd5);
    tick();
    applyStimulus(1'b1, 16'd7, 16'd9);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    tick();
    checkOutput("to_in_wait", 32'(busy), 32'd1);
    repeat (19) tick();
    checkOutput("to_still_wait_19", 32'(busy), 32'd1);
    checkOutput("to_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("to_back_idle", 32'(busy), 32'd0);
    checkOutput("to_err_set", 32'(timeout_err), 32'd1);
    checkOutput("to_no_result", 32'(res_valid), 32'd0);
    checkOutput("to_next_queued", 32'(fifo_count), 32'd1);
    stubNever   = 1'b0;
    stubLatency = 3;
    waitResult(20, "to_next_wait");
    checkOutput("to_next_product", res_product, 32'd63);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
    tick();
`else
    // Without the watchdog WAIT is left only by a done pulse
    $display("[TB] no watchdog");
    stubNever = 1'b1;
    applyStimulus(1'b1, 16'd5, 16'd5);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    repeat (32) tick();
    checkOutput("nowd_still_wait", 32'(busy), 32'd1);
    checkOutput("nowd_err_zero", 32'(timeout_err), 32'd0);
    checkOutput("nowd_no_result", 32'(res_valid), 32'd0);
    stubNever = 1'b0;
    forceDone = 1'b1;
    tick();
    forceDone = 1'b0;
    checkOutput("nowd_done_result", 32'(res_valid), 32'd1);
    checkOutput("nowd_done_product", res_product, 32'hDEAD_BEEF);
    tick();
`endif

    // Done coincides with the 20th WAIT cycle: product wins, no error
    $display("[TB] coincident done");
    stubNever = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    stubLatency = 20;
    applyStimulus(1'b1, 16'd6, 16'd7);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    tick();
    tick();
    repeat (19) tick();
    checkOutput("coin_no_result_e21", 32'(res_valid), 32'd0);
    checkOutput("coin_wait_e21", 32'(busy), 32'd1);
    tick();
    checkOutput("coin_result_e22", 32'(res_valid), 32'd1);
    checkOutput("coin_product", res_product, 32'd42);
    checkOutput("coin_no_err", 32'(timeout_err), 32'd0);
    checkOutput("coin_idle", 32'(busy), 32'd0);
    tick();

    // Reset in WAIT with two ops queued discards everything
    $display("[TB] reset mid-wait");
    stubNever = 1'b1;
    applyStimulus(1'b1, 16'd1, 16'd2);
    tick();
    applyStimulus(1'b1, 16'd3, 16'd4);
    tick();
    applyStimulus(1'b1, 16'd5, 16'd6);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    tick();
    checkOutput("mid_queued", 32'(fifo_count), 32'd2);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    checkOutput("mid_rst_op_ready", 32'(op_ready), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_fifo", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_mul_in_a", 32'(mul_in_a), 32'd0);
    checkOutput("mid_rst_mul_in_b", 32'(mul_in_b), 32'd0);
    checkOutput("mid_rst_valid_in", 32'(mul_valid_in), 32'd0);
    checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_rst_res_product", res_product, 32'd0);
    checkOutput("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b1;
    stubNever = 1'b0;
    tick();
    checkOutput("mid_post_fifo_empty", 32'(fifo_count), 32'd0);
    forceDone = 1'b1;
    tick();
    forceDone = 1'b0;
    checkOutput("mid_stale_no_result", 32'(res_valid), 32'd0);
    checkOutput("mid_stale_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    checkOutput("mid_stays_idle", 32'(busy), 32'd0);
    checkOutput("mid_stays_empty", 32'(fifo_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/booth_operand_issuer.md
# booth_operand_issuer

Upstream front end for `booth_multiplier`. Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. Issues each pair to the multiplier with a one-cycle `valid_in` pulse, holds the operands stable until `valid_out` returns, and presents the captured product on a valid/ready result stream. An optional watchdog aborts a multiply that never completes.

## Interface
- `WIDTH_INPUT`, 16: operand width; must match the multiplier.
- `WIDTH_OUTPUT`, 32: product width; must equal 2*WIDTH_INPUT.
- `FIFO_DEPTH`, 4: operand FIFO entries; power of two, >= 2.
- `TIMEOUT_CYCLES`, 20: WAIT-state cycles allowed before abort; only used with the watchdog compiled in.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `op_valid` in 1: upstream operand pair valid.
- `op_ready` out 1: FIFO can accept a pair.
- `op_a` in WIDTH_INPUT: multiplicand.
- `op_b` in WIDTH_INPUT: multiplier.
- `mul_in_a` out WIDTH_INPUT: drives multiplier `in_a`.
- `mul_in_b` out WIDTH_INPUT: drives multiplier `in_b`.
- `mul_valid_in` out 1: one-cycle start pulse to the multiplier.
- `mul_valid_out` in 1: multiplier done.
- `mul_product` in WIDTH_OUTPUT: multiplier product.
- `res_valid` out 1: result held.
- `res_ready` in 1: downstream accepts the result.
- `res_product` out WIDTH_OUTPUT: product.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy` out 1: FSM is not in IDLE.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- FIFO push on `op_valid && op_ready`.
- `op_ready = reset && (fifo_count != FIFO_DEPTH)`. There is no full-bypass: a push and a pop in the same cycle are allowed only when the FIFO is not full.
- The result slot is free when `!res_valid || res_ready`.
- The result handshake completes on `res_valid && res_ready`; `res_valid` then clears unless a new product is captured on the same edge.
- FSM states and transitions:
  - IDLE -> ISSUE when the FIFO is non-empty and the result slot is free. On this transition: pop, and register the head into `mul_in_a`/`mul_in_b`.
  - ISSUE -> WAIT unconditionally. `mul_valid_in` is 1 only while in ISSUE.
  - WAIT -> IDLE on `mul_valid_out`. On this transition: `res_product <= mul_product`, `res_valid <= 1`.
  - WAIT -> IDLE on timeout (watchdog compiled in). The operands are dropped, no result is produced, and `timeout_err` is set.
- `mul_in_a`/`mul_in_b` hold their value from the pop until the next pop, so they are stable throughout ISSUE and WAIT.
- `mul_valid_out` outside WAIT is ignored.
- Results leave in FIFO order; at most one multiply is in flight.
- The product is passed through unmodified; there is no width arithmetic beyond register widths.
- Reset values (while `reset` = 0): state IDLE, FIFO empty, all outputs 0, including `op_ready`, `timeout_err`, `mul_in_a`, `mul_in_b` and `res_product`.
- Reset asserted mid-operation (in ISSUE, WAIT or with `res_valid` high) discards FIFO contents, the pending result and any in-flight multiply. A late `mul_valid_out` after reset is ignored because the FSM is in IDLE.

## Timing
- Push at edge E0 (empty FIFO, slot free).
- Pop and ISSUE entry at E1; `mul_valid_in` is high for E1-E2.
- WAIT entry at E2.
- If `mul_valid_out` is sampled high at edge Ek, `res_valid` is high from Ek.
- End-to-end latency from push edge to `res_valid` = 2 + multiplier latency (cycles from `valid_in` sampled to `valid_out` sampled).
- Back-to-back throughput: the next pop occurs no earlier than the edge after capture, i.e. one idle cycle between multiplies.
- The watchdog counter clears on WAIT entry and increments each WAIT cycle. Timeout fires at the edge where the count reaches TIMEOUT_CYCLES with `mul_valid_out` low.
- If `mul_valid_out` and the timeout fall on the same edge, the product wins and no error is flagged.

## Configuration
- `BOOTH_ISSUER_TIMEOUT_EN` defined: watchdog counter present and `timeout_err` functional. It is sticky, cleared only by reset.
- Macro undefined: no counter, WAIT exits only on `mul_valid_out`, and `timeout_err` is tied to 0.

## Test plan
- Single op: after reset, push a=3, b=5, with a stub multiplier of latency 17 returning 15. Required:
  - `mul_valid_in` is a single one-cycle pulse.
  - `mul_in_a`=3, `mul_in_b`=5 stable until capture.
  - `res_product`=15 with `res_valid` high 19 cycles after the push edge.
- Backpressure/full: hold `res_ready`=0 and push 6 pairs (1×1 through 6×6). Required:
  - One pair is issued; its result is held.
  - `fifo_count` reaches 4 and `op_ready` drops, so the 6th pair stalls.
  - After releasing `res_ready`, products 1, 4, 9, 16, 25, 36 arrive in order.
- Spurious done: pulse `mul_valid_out` in IDLE and in ISSUE. Required: no `res_valid`, state unchanged.
- Timeout (macro on): the stub never asserts done. Required:
  - After 20 WAIT cycles, FSM returns to IDLE and `timeout_err`=1.
  - The next queued op (7×9) completes with 63.
  - `timeout_err` stays 1.
- Coincident done and timeout on the 20th WAIT cycle. Required: result captured, `timeout_err`=0.
- Reset mid-WAIT with 2 ops queued. Required:
  - All outputs are 0 during reset and the FIFO is empty afterwards.
  - A stale `mul_valid_out` after reset produces no result.
